// File: rtl/riscv_i32_trace_pack_pkg.sv
// riscv_i32_trace_pack_pkg: shared kinds, header layout and overflow limits for the trace packer
package riscv_i32_trace_pack_pkg;
  typedef enum logic [1:0] {
    KIND_SEQ      = 2'd0,
    KIND_BRANCH   = 2'd1,
    KIND_TRAP     = 2'd2,
    KIND_OVERFLOW = 2'd3
  } t_trace_pack_kind;
  localparam int HDR_KIND_LSB = 30;
  localparam int HDR_RFW_BIT = 29;
  localparam int HDR_RD_LSB = 24;
  localparam int HDR_PC_BITS = 24;
  localparam logic [23:0] DROP_COUNT_MAX = 24'hFFFFFF;
  function automatic logic [31:0] pack_header(t_trace_pack_kind kind, logic rfw, logic [4:0] rd,
                                              logic [HDR_PC_BITS-1:0] pc_word);
    return {kind, rfw, rd, pc_word};
  endfunction
endpackage

// File: rtl/riscv_i32_trace_pack_if.sv
// riscv_i32_trace_pack_if: trace bundle in, packed word stream out
interface riscv_i32_trace_pack_if;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        rfw_retire;
  logic        rfw_data_valid;
  logic [4:0]  rfw_rd;
  logic [31:0] rfw_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ack;
  modport master (
    output instr_valid, instr_pc, rfw_retire, rfw_data_valid, rfw_rd, rfw_data,
           branch_taken, branch_target, trap, out_ack,
    input  out_valid, out_data
  );
  modport slave (
    input  instr_valid, instr_pc, rfw_retire, rfw_data_valid, rfw_rd, rfw_data,
           branch_taken, branch_target, trap, out_ack,
    output out_valid, out_data
  );
endinterface

// File: rtl/riscv_i32_trace_word_fifo.sv
// riscv_i32_trace_word_fifo: word FIFO accepting 0..4 writes and at most one read per cycle
module riscv_i32_trace_word_fifo #(
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 clk_enable,
  input  logic                 reset_n,
  input  logic [2:0]           wr_count,
  input  logic [3:0][31:0]     wr_data,
  input  logic                 pop,
  output logic [FIFO_LOG2:0]   count,
  output logic [FIFO_LOG2:0]   free,
  output logic [31:0]          head
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  logic [31:0] mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign do_pop = pop & (count != '0);
  assign free = (FIFO_LOG2+1)'(DEPTH) - count;
  assign head = (count != '0) ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (clk_enable)
      for (int i = 0; i < 4; i++)
        if (3'(i) < wr_count) mem[wr_ptr + FIFO_LOG2'(i)] <= wr_data[i];
  always_ff @(posedge clk)
    if (clk_enable) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + FIFO_LOG2'(wr_count);
        rd_ptr <= rd_ptr + FIFO_LOG2'(do_pop);
        count  <= count + (FIFO_LOG2+1)'(wr_count) - (FIFO_LOG2+1)'(do_pop);
      end
    end
endmodule

// File: rtl/riscv_i32_trace_pack.sv
// riscv_i32_trace_pack: packs retired instructions into 1-3 words, with drop/overflow-marker handling
module riscv_i32_trace_pack
  import riscv_i32_trace_pack_pkg::*;
#(
  parameter int FIFO_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         clk__enable,
  input  logic                         reset_n,
  input  logic                         riscv_clk_enable,
  input  logic                         pack_enable,
  riscv_i32_trace_pack_if.slave        trace,
  output logic                         trace_overflow
);
  t_trace_pack_kind kind;
  logic cap, rfw, fits, emit_marker, push_instr, drop, overflow_pending;
  logic [1:0] n_words;
  logic [2:0] wr_count;
  logic [23:0] drop_count;
  logic [31:0] marker;
  logic [3:0][31:0] words, wr_data;
  logic [FIFO_LOG2:0] count, free;
  always_comb begin
    cap = clk__enable & riscv_clk_enable & pack_enable & trace.instr_valid;
    rfw = trace.rfw_retire & trace.rfw_data_valid;
    kind = trace.trap ? KIND_TRAP : trace.branch_taken ? KIND_BRANCH : KIND_SEQ;
    n_words = 2'd1 + 2'(rfw) + 2'(kind == KIND_BRANCH);
    marker = {KIND_OVERFLOW, 6'b0, drop_count};
    words = {32'b0, trace.branch_target, rfw ? trace.rfw_data : trace.branch_target,
             pack_header(kind, rfw, trace.rfw_rd, trace.instr_pc[25:2])};
    // a pending marker always occupies one extra slot ahead of the instruction
    fits = free >= (FIFO_LOG2+1)'(n_words) + (FIFO_LOG2+1)'(overflow_pending);
    emit_marker = overflow_pending & (cap ? fits : free != '0);
    push_instr = cap & fits;
    drop = cap & ~fits;
    wr_count = 3'(emit_marker) + (push_instr ? 3'(n_words) : 3'd0);
    wr_data = emit_marker ? {words[2:0], marker} : words;
  end
  always_ff @(posedge clk)
    if (clk__enable) begin
      if (!reset_n) begin
        overflow_pending <= 1'b0;
        drop_count       <= '0;
        trace_overflow   <= 1'b0;
      end else if (drop) begin
        overflow_pending <= 1'b1;
        trace_overflow   <= 1'b1;
        drop_count       <= !overflow_pending ? 24'd1 :
                            drop_count == DROP_COUNT_MAX ? drop_count : drop_count + 24'd1;
      end else if (emit_marker) begin
        overflow_pending <= 1'b0;
        drop_count       <= '0;
      end
    end
  riscv_i32_trace_word_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clk        (clk),
    .clk_enable (clk__enable),
    .reset_n    (reset_n),
    .wr_count   (wr_count),
    .wr_data    (wr_data),
    .pop        (trace.out_ack),
    .count      (count),
    .free       (free),
    .head       (trace.out_data)
  );
  assign trace.out_valid = count != '0;
endmodule
